ge_program_sequencer: RTL and testbench

- Multi-cycle executor for evolved register-machine individuals of the mul4_vector family: four 16-bit working registers r0..r3, initialised from operands a0/a1/b0/b1, then transformed by a loaded instruction program.
- Executes one instruction per clock from an internal program RAM and returns r3..r0 on y3..y0 through a valid/ready handshake.
- Lets one fixed block evaluate any individual of the tournament by reprogramming it, with no per-individual module.

---
 rtl/ge_program_sequencer.sv | 151 +++++++++++++++
 tb/tb_ge_program_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ge_program_sequencer.sv
// Register-machine executor: four WIDTH-bit registers seeded from the operands,
// transformed by a loaded program (one instruction per clock), result via valid/ready.
module ge_program_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [7:0]       prog_data,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b0,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y0
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_MOV, OP_AND, OP_OR, OP_XOR, OP_LNOT, OP_BNOT, OP_HALT
  } opcode_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             pc_q, pc_d;
  logic [AW:0]               len_q, len_d;
  logic [3:0][WIDTH-1:0]     r_q, r_d;
  logic [3:0][WIDTH-1:0]     opnd_q, opnd_d;
  logic [3:0][WIDTH-1:0]     y_q, y_d;

  logic [7:0]                ram [DEPTH];

  logic [7:0]                instr;
  opcode_e                   opcode;
  logic [1:0]                dst;
  logic [2:0]                src;
  logic [WIDTH-1:0]          src_val;
  logic [WIDTH-1:0]          alu_res;
  logic                      alu_wr;
  logic [AW:0]               pc_inc;
  logic [AW:0]               len_clamped;
  logic [3:0][WIDTH-1:0]     start_vals;

  // Program RAM has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) begin
      ram[prog_addr] <= prog_data;
    end
  end

  assign instr      = ram[pc_q];
  assign opcode     = opcode_e'(instr[7:5]);
  assign dst        = instr[4:3];
  assign src        = instr[2:0];
  assign src_val    = src[2] ? opnd_q[src[1:0]] : r_q[src[1:0]];
  assign pc_inc     = {1'b0, pc_q} + (AW+1)'(1);
  assign start_vals = {b1, b0, a1, a0};

  assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;

  always_comb begin
    alu_res = r_q[dst];
    alu_wr  = 1'b1;
    unique case (opcode)
      OP_MOV:  alu_res = src_val;
      OP_AND:  alu_res = r_q[dst] & src_val;
      OP_OR:   alu_res = r_q[dst] | src_val;
      OP_XOR:  alu_res = r_q[dst] ^ src_val;
      OP_LNOT: alu_res = WIDTH'(src_val == '0);
      OP_BNOT: alu_res = ~src_val;
      default: alu_wr  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    r_d     = r_q;
    opnd_d  = opnd_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d = start_vals;
          r_d    = start_vals;
          pc_d   = '0;
          len_d  = len_clamped;
          if (len_clamped == '0) begin
            y_d     = start_vals;
            state_d = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (alu_wr) begin
          r_d[dst] = alu_res;
        end
        pc_d = pc_inc[AW-1:0];
        // The result register captures the post-instruction values of this same edge.
        if ((pc_inc == len_q) || (opcode == OP_HALT)) begin
          y_d     = r_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      r_q     <= '0;
      opnd_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      r_q     <= r_d;
      opnd_q  <= opnd_d;
      y_q     <= y_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign y3        = y_q[3];
  assign y2        = y_q[2];
  assign y1        = y_q[1];
  assign y0        = y_q[0];

endmodule

// File: tb/tb_ge_program_sequencer.sv
// Scoreboard bench for ge_program_sequencer: a reference interpreter predicts each
// run's result and latency when start is driven; results are checked when out_valid rises.
module tb_ge_program_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [5:0]  prog_len;
  logic        start;
  logic [15:0] a1, a0, b1, b0;
  logic        busy, out_valid, out_ready;
  logic [15:0] y3, y2, y1, y0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0]  model_ram [32];
  logic [63:0] exp_q [$];
  int unsigned lat_q [$];
  logic [63:0] last_y;

  ge_program_sequencer #(.WIDTH(16), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .y3(y3), .y2(y2), .y1(y1), .y0(y0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  function automatic logic [7:0] enc(input int unsigned op, input int unsigned d, input int unsigned s);
    logic [2:0] o3 = op[2:0];
    logic [1:0] d2 = d[1:0];
    logic [2:0] s3 = s[2:0];
    return {o3, d2, s3};
  endfunction

  function automatic logic [63:0] model(input int unsigned len, input logic [15:0] ia0, ia1, ib0, ib1,
                                        output int unsigned n);
    logic [15:0] r [4];
    logic [15:0] o [4];
    logic [15:0] s;
    logic [7:0]  ins;
    int unsigned l;
    bit          halted = 0;
    r[0] = ia0; r[1] = ia1; r[2] = ib0; r[3] = ib1;
    o[0] = ia0; o[1] = ia1; o[2] = ib0; o[3] = ib1;
    l = (len > 32) ? 32 : len;
    n = 0;
    for (int unsigned i = 0; i < l && !halted; i++) begin
      ins = model_ram[i];
      n++;
      s = ins[2] ? o[ins[1:0]] : r[ins[1:0]];
      case (ins[7:5])
        3'd1: r[ins[4:3]] = s;
        3'd2: r[ins[4:3]] = r[ins[4:3]] & s;
        3'd3: r[ins[4:3]] = r[ins[4:3]] | s;
        3'd4: r[ins[4:3]] = r[ins[4:3]] ^ s;
        3'd5: r[ins[4:3]] = (s == 16'h0) ? 16'h0001 : 16'h0000;
        3'd6: r[ins[4:3]] = ~s;
        3'd7: halted = 1;
        default: ;
      endcase
    end
    return {r[3], r[2], r[1], r[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ram(input logic [4:0] addr, input logic [7:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    model_ram[addr] = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start_run(input int unsigned len, input logic [15:0] ia0, ia1, ib0, ib1);
    int unsigned n;
    logic [63:0] e;
    e = model(len, ia0, ia1, ib0, ib1, n);
    exp_q.push_back(e);
    lat_q.push_back(n + 1);
    prog_len = len[5:0];
    a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
    start = 1'b1;
    tick();
    start = 1'b0;
    a0 = 16'($urandom); a1 = 16'($urandom); b0 = 16'($urandom); b1 = 16'($urandom);
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_release: out_valid=%b busy=%b, required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic wait_result(input string name, input bit do_release);
    int unsigned n = 1;
    int unsigned lat;
    logic [63:0] e;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    e   = exp_q.pop_front();
    lat = lat_q.pop_front();
    last_y = e;
    tests++;
    if (out_valid !== 1'b1 || n != lat) begin
      fails++;
      $display("FAIL %s_latency: out_valid=%b after %0d edges, required 1 after %0d", name, out_valid, n, lat);
    end
    tests++;
    if ({y3, y2, y1, y0} !== e) begin
      fails++;
      $display("FAIL %s_y: y3..y0=%h %h %h %h, required %h", name, y3, y2, y1, y0, e);
    end
    if (do_release) release_result(name);
  endtask

  task automatic load_full();
    write_ram(5'd0, enc(4, 3, 1));
    write_ram(5'd1, enc(3, 0, 6));
    write_ram(5'd2, enc(5, 3, 2));
    write_ram(5'd3, enc(2, 2, 1));
    write_ram(5'd4, enc(5, 1, 0));
    write_ram(5'd5, enc(2, 0, 0));
    write_ram(5'd6, enc(3, 2, 7));
    write_ram(5'd7, enc(4, 2, 3));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || {y3, y2, y1, y0} !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b out_valid=%b y=%h%h%h%h, required 0 0 0", busy, out_valid, y3, y2, y1, y0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_program();
    load_full();
    start_run(8, 16'h00F0, 16'h0F0F, 16'h1234, 16'h0000);
    wait_result("full", 1'b0);
    tests++;
    if ({y3, y2, y1, y0} !== 64'h0000_0204_0000_12F4) begin
      fails++;
      $display("FAIL full_const: y=%h %h %h %h, required 0000 0204 0000 12f4", y3, y2, y1, y0);
    end
    release_result("full");
  endtask

  task automatic test_halt_lnot();
    write_ram(5'd0, enc(6, 0, 4));
    write_ram(5'd1, enc(7, 0, 0));
    write_ram(5'd2, enc(1, 1, 4));
    start_run(3, 16'h0000, 16'h0F0F, 16'h1111, 16'h2222);
    wait_result("halt", 1'b0);
    tests++;
    if (y0 !== 16'hFFFF || y1 !== 16'h0F0F) begin
      fails++;
      $display("FAIL halt_const: y1=%h y0=%h, required 0f0f ffff", y1, y0);
    end
    release_result("halt");
    write_ram(5'd0, enc(5, 2, 7));
    write_ram(5'd1, enc(5, 3, 6));
    start_run(2, 16'h7777, 16'h8888, 16'h0080, 16'h0000);
    wait_result("lnot", 1'b0);
    tests++;
    if (y2 !== 16'h0001 || y3 !== 16'h0000) begin
      fails++;
      $display("FAIL lnot_const: y3=%h y2=%h, required 0000 0001", y3, y2);
    end
    release_result("lnot");
  endtask

  task automatic test_zero_length();
    start_run(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    wait_result("zero_len", 1'b1);
  endtask

  task automatic test_len_clamp();
    for (int i = 0; i < 32; i++) write_ram(5'(i), enc(4, 0, 5));
    start_run(33, 16'h00FF, 16'hF00F, 16'h1357, 16'h2468);
    wait_result("clamp", 1'b1);
  endtask

  task automatic test_backpressure();
    write_ram(5'd0, enc(1, 0, 7));
    start_run(1, 16'h0001, 16'h0002, 16'h0003, 16'h5A5A);
    wait_result("bp", 1'b0);
    for (int c = 0; c < 5; c++) begin
      start    = (c == 0);
      prog_len = 6'd1;
      prog_we  = (c == 2);
      prog_addr = 5'd0;
      prog_data = enc(1, 0, 5);
      tick();
      tests++;
      if (out_valid !== 1'b1 || {y3, y2, y1, y0} !== last_y) begin
        fails++;
        $display("FAIL bp_hold_%0d: out_valid=%b y=%h%h%h%h, required 1 %h", c, out_valid, y3, y2, y1, y0, last_y);
      end
    end
    start = 1'b0; prog_we = 1'b0;
    release_result("bp");
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_start_queued: busy=%b, required 0", busy);
    end
    start_run(1, 16'h0000, 16'h1111, 16'h2222, 16'hC3C3);
    wait_result("bp_readback", 1'b1);
  endtask

  task automatic test_collision();
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = enc(1, 0, 7);
    model_ram[0] = enc(1, 0, 7);
    start_run(1, 16'h0000, 16'h1111, 16'h2222, 16'hABCD);
    prog_we = 1'b0;
    wait_result("collision", 1'b0);
    tests++;
    if (y0 !== 16'hABCD) begin
      fails++;
      $display("FAIL collision_const: y0=%h, required abcd", y0);
    end
    release_result("collision");
  endtask

  task automatic test_reset_mid();
    load_full();
    start_run(8, 16'h00F0, 16'h0F0F, 16'h1234, 16'h0000);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || {y3, y2, y1, y0} !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b out_valid=%b y=%h%h%h%h, required 0 0 0", busy, out_valid, y3, y2, y1, y0);
    end
    #1 rst_n = 1'b1;
    tick();
    start_run(8, 16'hFF00, 16'h00FF, 16'h0000, 16'h8001);
    wait_result("ram_retained", 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; a0 = '0; a1 = '0; b0 = '0; b1 = '0; out_ready = 1'b0;
    test_reset();
    test_full_program();
    test_halt_lnot();
    test_zero_length();
    test_len_clamp();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
